// File: rtl/pulse_stretch_pkg.sv
// Shared helpers for the pulse stretcher: pending-queue arithmetic used by the
// top-level next-state logic.
package pulse_stretch_pkg;

  // New queue occupancy after an optional enqueue and an optional dequeue in
  // the same cycle. Callers guarantee no underflow (dec only when cur > 0).
  function automatic int unsigned pend_next(input int unsigned cur,
                                            input logic        inc,
                                            input logic        dec);
    int unsigned nxt;
    nxt = cur;
    if (inc) nxt = nxt + 32'd1;
    if (dec) nxt = nxt - 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches one-cycle event strobes into HOLD_CYCLES-wide pulses separated by
// GAP_CYCLES low cycles, queueing up to MAX_PEND events that arrive meanwhile.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_PEND    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            p,
  output logic                            z,
  output logic                            busy,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend,
  output logic                            ovf
);

  localparam int unsigned PendW = $clog2(MAX_PEND + 1);
  localparam int unsigned CntW  = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHold = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [CntW-1:0]  HoldLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  GapLoad  = CntW'(GAP_CYCLES - 1);
  localparam logic [PendW-1:0] PendMax  = PendW'(MAX_PEND);

  logic [1:0]       r_state;
  logic [CntW-1:0]  r_cnt;
  logic [PendW-1:0] r_pend;
  logic             r_drop;

  logic [1:0]       w_state_nxt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic [PendW-1:0] w_pend_nxt;
  logic             w_serve;
  logic             w_take;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_serve     = 1'b0;
    w_take      = 1'b0;
    w_dec       = 1'b0;

    case (r_state)
      StIdle: begin
        if (p) begin
          w_state_nxt = StHold;
          w_cnt_nxt   = HoldLoad;
        end
      end
      StHold: begin
        w_take = p;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end else if (GAP_CYCLES != 0) begin
          w_state_nxt = StGap;
          w_cnt_nxt   = GapLoad;
        end else begin
          w_serve = 1'b1;
        end
      end
      StGap: begin
        w_take = p;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end else begin
          w_serve = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase

    // Queued events are served before a fresh strobe; a strobe that starts the
    // next pulse directly is consumed and never enters the queue.
    if (w_serve) begin
      if (r_pend != '0) begin
        w_dec       = 1'b1;
        w_state_nxt = StHold;
        w_cnt_nxt   = HoldLoad;
      end else if (p) begin
        w_take      = 1'b0;
        w_state_nxt = StHold;
        w_cnt_nxt   = HoldLoad;
      end else begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    end

    w_inc      = w_take && ((r_pend != PendMax) || w_dec);
    w_drop     = w_take && !w_inc;
    w_pend_nxt = PendW'(pend_next(32'(r_pend), w_inc, w_dec));
  end

  // Outputs are a registered view of the internal state, so nothing reaches
  // them combinationally from p.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_drop  <= 1'b0;
      z       <= 1'b0;
      busy    <= 1'b0;
      pend    <= '0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_drop  <= w_drop;
      z       <= (r_state == StHold);
      busy    <= (r_state != StIdle);
      pend    <= r_pend;
      ovf     <= r_drop;
    end
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles z is high per event (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, giving the number of low cycles forced between consecutive stretched pulses (legal range 0..255).
REQ-003 SHALL have parameter MAX_PEND, default 3, giving the pending-event queue depth (legal range 1..15).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 p  input  1  event strobe, one-cycle pulse per event (typ. from the edge detector).
REQ-007 z  output  1  stretched pulse, registered.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 pend  output  clog2(MAX_PEND+1)  count of queued, not-yet-served events.
REQ-010 ovf  output  1  one-cycle pulse; an event was dropped.

Function
REQ-011 SHALL implement three states: IDLE, HOLD, GAP, plus an internal down-counter of 8 bits.
REQ-012 IDLE: p=1 SHALL move to HOLD next cycle with counter=HOLD_CYCLES-1; p=0 SHALL stay in IDLE.
REQ-013 HOLD: counter SHALL decrement each cycle; z SHALL be 1 in every HOLD cycle and 0 otherwise (1-cycle latency from p to z).
REQ-014 HOLD terminal (counter=0): if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1; else apply the serve rule (REQ-016).
REQ-015 GAP: counter SHALL decrement each cycle; at terminal apply the serve rule.
REQ-016 Serve rule: if pend>0, decrement pend and re-enter HOLD; else if p=1, re-enter HOLD without touching pend; else go to IDLE.
REQ-017 p=1 in HOLD/GAP outside a serve that consumes it SHALL increment pend.
REQ-018 Simultaneous p=1 and a pend-consuming serve SHALL leave pend unchanged.
REQ-019 p=1 with pend=MAX_PEND and no consumption that cycle SHALL drop the event, hold pend, and pulse ovf the next cycle.
REQ-020 With GAP_CYCLES=0, back-to-back serves SHALL keep z continuously high for N*HOLD_CYCLES cycles.
REQ-021 busy, pend and ovf SHALL be registered, with no combinational path from p.

Reset
REQ-022 rst SHALL force state=IDLE, counter=0, pend=0, z=0, busy=0 and ovf=0 on the next edge.
REQ-023 rst SHALL take priority over p; an event coincident with rst SHALL be discarded.
REQ-024 rst mid-HOLD or mid-GAP SHALL abort the pulse and flush all pending events; no pulse resumes after reset.

Structure
REQ-025 State encoding and counter width SHALL be localparams inside the module; no shared package entry is required.
REQ-026 SHALL be a single module with no sub-modules; the edge detector upstream is instantiated by the parent, not inside this block.

Verification (defaults HOLD=4, GAP=2, MAX_PEND=3; cycle numbers count rising edges)
REQ-027 Single p at cycle 10 -> z=1 cycles 11-14; busy=1 cycles 11-16; pend=0 throughout; ovf never high.
REQ-028 p at 10 and 12 -> z=1 cycles 11-14 and 17-20; pend=1 cycles 13-16; busy stays high 11-22.
REQ-029 p at 10 then every cycle 11-14 -> pend reaches 3 at cycle 14; ovf=1 at cycle 15; exactly four pulses total.
REQ-030 p at 10 and 16 (pend=0 at GAP terminal) -> z=1 cycles 11-14 and 17-20; pend stays 0.
REQ-031 p at 10 and 12, rst at cycle 12 -> z=0, busy=0, pend=0 from cycle 13; no further z activity.
REQ-032 With GAP_CYCLES=0, p at 10 and 11 -> z=1 continuously cycles 11-18; busy falls at cycle 19.
